// File: rtl/apb_requester.sv
// APB4 requester: turns valid/ready commands into single APB transfers, one outstanding at a time.
// Optional ACCESS-phase timeout abort is built only when APB_TIMEOUT_EN is defined.
module apb_requester #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_write,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic                psel,
    output logic                penable,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;

    if ((DATA_W % 8) != 0 || DATA_W == 0) begin : gen_bad_data_w
        $error("apb_requester: DATA_W must be a non-zero multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_slverr_q, rsp_slverr_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned      CNT_W        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pstrb_d      = pstrb_q;
        pwdata_d     = pwdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
`ifdef APB_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d  = StSetup;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    // Reads drive zero strobes and data on the bus.
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                end
            end
            StSetup: begin
                state_d = StAccess;
`ifdef APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StAccess: begin
                if (pready) begin
                    state_d       = StResp;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_slverr_d  = pslverr;
`ifdef APB_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
`ifdef APB_TIMEOUT_EN
                // cnt_q counts earlier wait cycles, so this is the last allowed ACCESS cycle.
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = StResp;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        cmd_ready_d = (state_d == StIdle);
        psel_d      = (state_d == StSetup) || (state_d == StAccess);
        penable_d   = (state_d == StAccess);
        rsp_valid_d = (state_d == StResp);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pstrb_q      <= '0;
            pwdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pstrb_q      <= pstrb_d;
            pwdata_q     <= pwdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pstrb      = pstrb_q;
    assign pwdata     = pwdata_q;

endmodule
